// File: rtl/srt4_pkg.sv
// srt4_pkg: shared types and codes for the SRT radix-4 divider arbiter.
// Holds FSM states, response status codes and the default operand width.
package srt4_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DBZ     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/srt4_div_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request
// at or after ptr, searching upward with wrap.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   j;
    logic hit;
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/srt4_div_arbiter.sv
// srt4_div_arbiter: round-robin share of one SRT radix-4 divider.
// Optional busy watchdog is built when SRT4_ARB_TIMEOUT_EN is defined.
module srt4_div_arbiter
  import srt4_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_q,
  output logic [WIDTH-1:0]         rsp_r,
  output logic [1:0]               rsp_err,
  output logic                     div_begin,
  output logic [WIDTH-1:0]         div_a,
  output logic [WIDTH-1:0]         div_b,
  input  logic                     div_end,
  input  logic [WIDTH-1:0]         div_q,
  input  logic [WIDTH-1:0]         div_r,
  output logic                     busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("srt4_div_arbiter: parameter out of range");
  end

  state_t state, state_nx;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gsel;
  logic [IW-1:0]      gidx;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0]   a_g;
  logic [WIDTH-1:0]   b_g;
  logic               accept;
  logic               dbz;
  logic               done_ok;
  logic               done_to;
  logic               rsp_fire;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  assign a_g = req_a[int'(gidx)*WIDTH +: WIDTH];
  assign b_g = req_b[int'(gidx)*WIDTH +: WIDTH];

  assign accept   = (state == S_IDLE) && (|req_valid);
  assign dbz      = (b_g == '0);
  assign done_ok  = (state == S_BUSY) && div_end;
  assign rsp_fire = (state == S_RESP) && rsp_ready[gsel];

`ifdef SRT4_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wd_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wd_cnt <= '0;
    end else if (state == S_BUSY) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires when this BUSY cycle brings the count to TIMEOUT-1.
  assign done_to = (state == S_BUSY) && !div_end &&
                   (wd_cnt == CW'(TIMEOUT - 2));
`else
  assign done_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (accept) state_nx = dbz ? S_RESP : S_LAUNCH;
      S_LAUNCH: state_nx = S_BUSY;
      S_BUSY:   if (done_ok || done_to) state_nx = S_RESP;
      S_RESP:   if (rsp_fire) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr  <= '0;
      gsel    <= '0;
      div_a   <= '0;
      div_b   <= '0;
      rsp_q   <= '0;
      rsp_r   <= '0;
      rsp_err <= ERR_OK;
    end else begin
      if (accept) begin
        gsel  <= gidx;
        div_a <= a_g;
        div_b <= b_g;
        if (dbz) begin
          rsp_q   <= '1;
          rsp_r   <= a_g;
          rsp_err <= ERR_DBZ;
        end
      end
      if (done_ok) begin
        rsp_q   <= div_q;
        rsp_r   <= div_r;
        rsp_err <= ERR_OK;
      end else if (done_to) begin
        rsp_q   <= '0;
        rsp_r   <= '0;
        rsp_err <= ERR_TIMEOUT;
      end
      if (rsp_fire) begin
        rr_ptr <= (int'(gsel) == NUM_REQ - 1) ? '0 : gsel + 1'b1;
      end
    end
  end

  assign req_ready = (state == S_IDLE) ? gnt : '0;
  assign rsp_valid = (state == S_RESP) ? (NUM_REQ'(1) << gsel) : '0;
  assign div_begin = (state == S_LAUNCH);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_srt4_div_arbiter.sv
// tb_srt4_div_arbiter: scoreboard bench with a divider model,
// directed latency cases and randomized multi-requester traffic.
`timescale 1ns/1ps
module tb_srt4_div_arbiter;
  import srt4_pkg::*;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst_b;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   rsp_q, rsp_r, div_a, div_b, div_q, div_r;
  logic [1:0]     rsp_err;
  logic           div_begin, div_end, busy;

  always #5 clk = ~clk;

  srt4_div_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .div_begin(div_begin), .div_a(div_a), .div_b(div_b),
    .div_end(div_end), .div_q(div_q), .div_r(div_r),
    .busy(busy)
  );

  typedef struct {
    int         idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [1:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   glog[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ptr_m = 0;
  bit   m_idle = 1;
  int   begin_cnt = 0;
  int   last_begin = -1;
  int   div_lat = 3;
  bit   hang = 0;
  bit   stray_en = 0;
  bit   stray_go = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Divider model: answers L cycles after the start pulse.
  initial begin
    int dcnt;
    bit infl;
    logic [W-1:0] da, db;
    dcnt = 0; infl = 0; da = 0; db = 1;
    div_end = 0; div_q = 0; div_r = 0;
    forever begin
      tick();
      div_end = 0;
      if (!rst_b) begin
        dcnt = 0;
        infl = 0;
      end else begin
        if (infl && dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            div_end = 1;
            div_q = da / db;
            div_r = da % db;
            infl = 0;
          end
        end else if (!infl && !div_begin &&
                     (stray_go || (stray_en && $urandom_range(0, 7) == 0))) begin
          div_end = 1;
          div_q = W'($urandom);
          div_r = W'($urandom);
          stray_go = 0;
        end
        if (div_begin && !hang) begin
          infl = 1;
          dcnt = div_lat;
          da = div_a;
          db = div_b;
        end
      end
    end
  end

  // Monitor: grant prediction, busy tracking, response scoreboard.
  initial begin
    int g;
    exp_t e;
    logic [W-1:0] a, b;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_begin", div_begin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_q", rsp_q, 0);
        chk("rst_rsp_r", rsp_r, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);
        exp_q.delete();
        ptr_m = 0;
        m_idle = 1;
      end else begin
        chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
        chk("valid_onehot0", 32'($onehot0(rsp_valid)), 1);
        chk("busy", busy, 32'(!m_idle));
        if (div_begin) begin
          begin_cnt++;
          last_begin = cyc;
        end
        if (m_idle) begin
          g = pick(req_valid, ptr_m);
          chk("grant", req_ready, (g < 0) ? 0 : (1 << g));
          if (g >= 0 && req_ready[g]) begin
            a = req_a[g*W +: W];
            b = req_b[g*W +: W];
            e.idx = g;
            if (b == 0) begin
              e.q = '1; e.r = a; e.err = 2'b01;
            end else if (hang) begin
              e.q = 0; e.r = 0; e.err = 2'b10;
            end else begin
              e.q = a / b; e.r = a % b; e.err = 2'b00;
            end
            exp_q.push_back(e);
            glog.push_back(g);
            m_idle = 0;
          end
        end else begin
          chk("ready_when_busy", req_ready, 0);
        end
        if (rsp_valid != 0) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 0);
          end else begin
            e = exp_q[0];
            chk("rsp_who", rsp_valid, 1 << e.idx);
            chk("rsp_q", rsp_q, e.q);
            chk("rsp_r", rsp_r, e.r);
            chk("rsp_err", rsp_err, e.err);
            if (rsp_ready[e.idx]) begin
              void'(exp_q.pop_front());
              ptr_m = (e.idx + 1) % N;
              m_idle = 1;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(m_idle && exp_q.size() == 0) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_reached", n < 300, 1);
  endtask

  task automatic wait_accept(input int i, input string nm);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (req_ready[i]) break;
      n++;
    end
    chk({nm, "_accept"}, req_ready[i], 1);
  endtask

  task automatic send_timed(input int i, input int a, input int b,
                            input int lat, input string nm,
                            output int t0);
    int n;
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_valid[i] = 1;
    wait_accept(i, nm);
    t0 = cyc;
    tick();
    req_valid[i] = 0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (rsp_valid[i]) break;
      n++;
    end
    chk({nm, "_lat"}, cyc - t0, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t0, bc0;
    logic [N-1:0] v0;
    logic [W-1:0] q0, r0;
    logic [1:0] e0;
    rst_b = 0;
    req_valid = 0;
    rsp_ready = '1;
    req_a = 0;
    req_b = 0;
    repeat (3) tick();
    rst_b = 1;
    tick();

    // Single request, divider ends 12 cycles after start.
    div_lat = 12;
    bc0 = begin_cnt;
    send_timed(0, 100, 7, 14, "single", t0);
    chk("single_begin_cyc", last_begin - t0, 1);
    chk("single_begin_cnt", begin_cnt - bc0, 1);
    wait_idle();

    // Divide-by-zero answered locally.
    bc0 = begin_cnt;
    send_timed(1, 55, 0, 1, "dbz", t0);
    wait_idle();
    chk("dbz_no_begin", begin_cnt - bc0, 0);

    // Both requesters valid continuously.
    div_lat = 2;
    glog.delete();
    req_valid = '1;
    for (int n = 0; n < 200 && glog.size() < 4; n++) begin
      req_a = (N*W)'($urandom);
      req_b = (N*W)'($urandom);
      tick();
    end
    req_valid = 0;
    wait_idle();
    for (int k = 0; k < 4; k++)
      chk("rr_order", (glog.size() > k) ? glog[k] : -1, k % 2);

    // Response backpressure.
    div_lat = 3;
    rsp_ready = 0;
    req_a = {8'd50, 8'd200};
    req_b = {8'd5, 8'd9};
    req_valid = 2'b01;
    wait_accept(0, "bp");
    tick();
    req_valid = 2'b10;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp_valid != 0) break;
    end
    v0 = rsp_valid; q0 = rsp_q; r0 = rsp_r; e0 = rsp_err;
    chk("bp_valid", v0, 1);
    chk("bp_q", q0, 22);
    chk("bp_r", r0, 2);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, v0);
      chk("bp_hold_q", rsp_q, q0);
      chk("bp_hold_r", rsp_r, r0);
      chk("bp_hold_err", rsp_err, e0);
      chk("bp_no_ready", req_ready, 0);
    end
    tick();
    rsp_ready = '1;
    wait_accept(1, "bp_next");
    tick();
    req_valid = 0;
    wait_idle();

    // Reset during BUSY, then a fresh request.
    div_lat = 30;
    req_a[0 +: W] = 8'd77;
    req_b[0 +: W] = 8'd5;
    req_valid[0] = 1;
    wait_accept(0, "mid");
    tick();
    req_valid[0] = 0;
    repeat (5) tick();
    chk("mid_busy_before", busy, 1);
    rst_b = 0;
    #1;
    chk("mid_async_busy", busy, 0);
    chk("mid_async_div_a", div_a, 0);
    repeat (3) tick();
    rst_b = 1;
    tick();
    div_lat = 4;
    send_timed(0, 77, 5, 6, "after_rst", t0);
    wait_idle();

    // Randomized traffic with stray divider pulses.
    stray_en = 1;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_a[i*W +: W] = W'($urandom);
        req_b[i*W +: W] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      div_lat = $urandom_range(1, 6);
      tick();
    end
    stray_en = 0;
    req_valid = 0;
    rsp_ready = '1;
    wait_idle();

`ifdef SRT4_ARB_TIMEOUT_EN
    hang = 1;
    send_timed(0, 9, 3, TO + 1, "wd", t0);
    wait_idle();
    hang = 0;
    stray_go = 1;
    repeat (4) tick();
    chk("wd_stray_busy", busy, 0);
    div_lat = 2;
    send_timed(1, 9, 3, 4, "wd_after", t0);
    wait_idle();
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
